// File: rtl/mem_bus_bridge.sv
// Bridges the core's single-cycle data-memory port onto a valid/ready request
// channel and a response channel, stalling the core until each transaction ends.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic        o_req_we,
    output logic [31:0] o_req_addr,
    output logic [31:0] o_req_wdata,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          in_flight;
    logic          timeout_hit;
    logic          capture;
    logic          rsp_take;
    logic          to_done;

    assign in_flight   = (state == REQ) || (state == RSP);
    // The counter value entering its last allowed cycle; DONE follows at this edge.
    assign timeout_hit = (TIMEOUT != 0) && in_flight && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rsp_take  = 1'b0;
        to_done   = 1'b0;
        case (state)
            IDLE: begin
                if (i_read_en || i_write_en) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    to_done   = 1'b1;
                    state_nxt = DONE;
                end else if (i_req_ready) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                // A response landing on the timeout cycle still counts as success.
                if (i_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    to_done   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_req_valid <= 1'b0;
            o_req_we    <= 1'b0;
            o_req_addr  <= '0;
            o_req_wdata <= '0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_req_valid <= (state_nxt == REQ);
            o_busy      <= (state_nxt == REQ) || (state_nxt == RSP);
            o_err       <= to_done;

            if (capture) begin
                o_req_addr  <= i_addr;
                o_req_wdata <= i_wdata;
                o_req_we    <= i_write_en;
                cnt         <= '0;
            end else if (in_flight && (cnt != '1)) begin
                cnt <= cnt + CW'(1);
            end

            // Write responses carry no data, so o_rdata keeps its last read value.
            if (rsp_take && !o_req_we) begin
                o_rdata <= i_rsp_data;
            end else if (to_done) begin
                o_rdata <= ERR_DATA;
            end
        end
    end

    assign o_stall = (i_read_en | i_write_en) & (state != DONE);

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: handshake timing, stalls, back-to-back,
// timeout, asynchronous reset and write priority.
module tb_mem_bus_bridge;

    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_req_valid;
    logic        ready;
    logic        o_req_we;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        o_err;
    logic        o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_bus_bridge #(.TIMEOUT(16), .ERR_DATA(ERR_VAL)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read_en   (rd),
        .i_write_en  (wr),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_req_valid (o_req_valid),
        .i_req_ready (ready),
        .o_req_we    (o_req_we),
        .o_req_addr  (o_req_addr),
        .o_req_wdata (o_req_wdata),
        .i_rsp_valid (rsp_valid),
        .i_rsp_data  (rsp_data),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        if (o_req_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", o_req_valid); n_fail++; end n_cmp++;
        if (o_req_we !== 1'b0) begin $display("FAIL rst_we got=%b exp=0", o_req_we); n_fail++; end n_cmp++;
        if (o_req_addr !== 32'h0) begin $display("FAIL rst_addr got=%h exp=0", o_req_addr); n_fail++; end n_cmp++;
        if (o_req_wdata !== 32'h0) begin $display("FAIL rst_wdata got=%h exp=0", o_req_wdata); n_fail++; end n_cmp++;
        if (o_rdata !== 32'h0) begin $display("FAIL rst_rdata got=%h exp=0", o_rdata); n_fail++; end n_cmp++;
        if (o_err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", o_err); n_fail++; end n_cmp++;
        if (o_busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", o_busy); n_fail++; end n_cmp++;
        if (o_stall !== 1'b0) begin $display("FAIL rst_stall got=%b exp=0", o_stall); n_fail++; end n_cmp++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int stall_cnt = 0;
        rd = 1'b1; addr = 32'h100; ready = 1'b1;
        #1;
        if (o_stall !== 1'b1) begin $display("FAIL rd_stall_c0 got=%b exp=1", o_stall); n_fail++; end n_cmp++;
        stall_cnt += int'(o_stall);
        tick();
        if (o_req_valid !== 1'b1) begin $display("FAIL rd_valid_req got=%b exp=1", o_req_valid); n_fail++; end n_cmp++;
        if (o_req_addr !== 32'h100) begin $display("FAIL rd_addr got=%h exp=00000100", o_req_addr); n_fail++; end n_cmp++;
        if (o_req_we !== 1'b0) begin $display("FAIL rd_we got=%b exp=0", o_req_we); n_fail++; end n_cmp++;
        #1 stall_cnt += int'(o_stall);
        tick();
        if (o_req_valid !== 1'b0) begin $display("FAIL rd_valid_rsp got=%b exp=0", o_req_valid); n_fail++; end n_cmp++;
        rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
        #1 stall_cnt += int'(o_stall);
        tick();
        rsp_valid = 1'b0;
        #1;
        if (o_stall !== 1'b0) begin $display("FAIL rd_stall_done got=%b exp=0", o_stall); n_fail++; end n_cmp++;
        if (o_rdata !== 32'hCAFE_F00D) begin $display("FAIL rd_rdata got=%h exp=cafef00d", o_rdata); n_fail++; end n_cmp++;
        if (o_err !== 1'b0) begin $display("FAIL rd_err got=%b exp=0", o_err); n_fail++; end n_cmp++;
        if (stall_cnt !== 3) begin $display("FAIL rd_stall_cycles got=%0d exp=3", stall_cnt); n_fail++; end n_cmp++;
        rd = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        int stall_cnt = 0;
        int vcnt = 0;
        wr = 1'b1; addr = 32'h200; wdata = 32'h1234_5678; rsp_data = 32'h0BAD_0BAD;
        for (int c = 0; c < 7; c++) begin
            ready = (c >= 4);
            rsp_valid = (c == 5);
            #1;
            stall_cnt += int'(o_stall);
            vcnt += int'(o_req_valid);
            if (c >= 1 && c <= 4) begin
                if (o_req_addr !== 32'h200) begin $display("FAIL wr_addr c=%0d got=%h exp=00000200", c, o_req_addr); n_fail++; end n_cmp++;
                if (o_req_wdata !== 32'h1234_5678) begin $display("FAIL wr_wdata c=%0d got=%h exp=12345678", c, o_req_wdata); n_fail++; end n_cmp++;
                if (o_req_we !== 1'b1) begin $display("FAIL wr_we c=%0d got=%b exp=1", c, o_req_we); n_fail++; end n_cmp++;
            end
            if (c == 6) begin
                if (o_stall !== 1'b0) begin $display("FAIL wr_stall_done got=%b exp=0", o_stall); n_fail++; end n_cmp++;
                if (o_rdata !== 32'hCAFE_F00D) begin $display("FAIL wr_rdata_kept got=%h exp=cafef00d", o_rdata); n_fail++; end n_cmp++;
            end
            tick();
        end
        wr = 1'b0; rsp_valid = 1'b0;
        if (stall_cnt !== 6) begin $display("FAIL wr_stall_cycles got=%0d exp=6", stall_cnt); n_fail++; end n_cmp++;
        if (vcnt !== 4) begin $display("FAIL wr_valid_cycles got=%0d exp=4", vcnt); n_fail++; end n_cmp++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [2] = '{32'h10, 32'h14};
        logic [31:0] d [2] = '{32'hA, 32'hB};
        ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            rd = 1'b1; addr = a[t];
            #1;
            if (o_stall !== 1'b1) begin $display("FAIL b2b_stall_idle t=%0d got=%b exp=1", t, o_stall); n_fail++; end n_cmp++;
            if (o_req_valid !== 1'b0) begin $display("FAIL b2b_no_overlap t=%0d got=%b exp=0", t, o_req_valid); n_fail++; end n_cmp++;
            tick();
            if (o_req_valid !== 1'b1) begin $display("FAIL b2b_valid t=%0d got=%b exp=1", t, o_req_valid); n_fail++; end n_cmp++;
            if (o_req_addr !== a[t]) begin $display("FAIL b2b_addr t=%0d got=%h exp=%h", t, o_req_addr, a[t]); n_fail++; end n_cmp++;
            tick();
            rsp_valid = 1'b1; rsp_data = d[t];
            tick();
            rsp_valid = 1'b0;
            #1;
            if (o_stall !== 1'b0) begin $display("FAIL b2b_stall_done t=%0d got=%b exp=0", t, o_stall); n_fail++; end n_cmp++;
            if (o_rdata !== d[t]) begin $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, o_rdata, d[t]); n_fail++; end n_cmp++;
            tick();
        end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_timeout_rsp();
        rd = 1'b1; addr = 32'h40; ready = 1'b1; rsp_valid = 1'b0;
        tick();
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (o_stall !== 1'b1 || o_err !== 1'b0) begin
                $display("FAIL to_wait c=%0d got stall=%b err=%b exp stall=1 err=0", c, o_stall, o_err); n_fail++;
            end
            n_cmp++;
            tick();
        end
        #1;
        if (o_stall !== 1'b0) begin $display("FAIL to_stall_done got=%b exp=0", o_stall); n_fail++; end n_cmp++;
        if (o_err !== 1'b1) begin $display("FAIL to_err got=%b exp=1", o_err); n_fail++; end n_cmp++;
        if (o_rdata !== ERR_VAL) begin $display("FAIL to_rdata got=%h exp=%h", o_rdata, ERR_VAL); n_fail++; end n_cmp++;
        rd = 1'b0;
        tick();
        if (o_err !== 1'b0) begin $display("FAIL to_err_pulse got=%b exp=0", o_err); n_fail++; end n_cmp++;
        tick();
        rsp_valid = 1'b1; rsp_data = 32'h1234_0000;
        tick();
        rsp_valid = 1'b0;
        #1;
        if (o_busy !== 1'b0) begin $display("FAIL to_late_busy got=%b exp=0", o_busy); n_fail++; end n_cmp++;
        if (o_rdata !== ERR_VAL) begin $display("FAIL to_late_rdata got=%h exp=%h", o_rdata, ERR_VAL); n_fail++; end n_cmp++;
        if (o_req_valid !== 1'b0) begin $display("FAIL to_late_valid got=%b exp=0", o_req_valid); n_fail++; end n_cmp++;
        if (o_err !== 1'b0) begin $display("FAIL to_late_err got=%b exp=0", o_err); n_fail++; end n_cmp++;
        tick();
    endtask

    task automatic test_timeout_req();
        int vcnt = 0;
        wr = 1'b1; addr = 32'h50; wdata = 32'h5; ready = 1'b0;
        tick();
        for (int c = 1; c <= 16; c++) begin
            #1 vcnt += int'(o_req_valid);
            tick();
        end
        #1;
        if (o_req_valid !== 1'b0) begin $display("FAIL toq_valid_drop got=%b exp=0", o_req_valid); n_fail++; end n_cmp++;
        if (o_err !== 1'b1) begin $display("FAIL toq_err got=%b exp=1", o_err); n_fail++; end n_cmp++;
        if (vcnt !== 16) begin $display("FAIL toq_valid_cycles got=%0d exp=16", vcnt); n_fail++; end n_cmp++;
        wr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        rd = 1'b1; addr = 32'h60; ready = 1'b1; rsp_valid = 1'b0;
        tick();
        tick();
        #1;
        if (o_busy !== 1'b1) begin $display("FAIL rm_busy_rsp got=%b exp=1", o_busy); n_fail++; end n_cmp++;
        #1;
        rst = 1'b0; rd = 1'b0;
        #1;
        if (o_req_valid !== 1'b0) begin $display("FAIL rm_valid got=%b exp=0", o_req_valid); n_fail++; end n_cmp++;
        if (o_req_addr !== 32'h0) begin $display("FAIL rm_addr got=%h exp=0", o_req_addr); n_fail++; end n_cmp++;
        if (o_rdata !== 32'h0) begin $display("FAIL rm_rdata got=%h exp=0", o_rdata); n_fail++; end n_cmp++;
        if (o_busy !== 1'b0) begin $display("FAIL rm_busy got=%b exp=0", o_busy); n_fail++; end n_cmp++;
        if (o_err !== 1'b0) begin $display("FAIL rm_err got=%b exp=0", o_err); n_fail++; end n_cmp++;
        if (o_stall !== 1'b0) begin $display("FAIL rm_stall got=%b exp=0", o_stall); n_fail++; end n_cmp++;
        tick();
        rst = 1'b1;
        tick();
        rd = 1'b1; addr = 32'h64;
        tick();
        if (o_req_valid !== 1'b1) begin $display("FAIL rm_new_valid got=%b exp=1", o_req_valid); n_fail++; end n_cmp++;
        if (o_req_addr !== 32'h64) begin $display("FAIL rm_new_addr got=%h exp=00000064", o_req_addr); n_fail++; end n_cmp++;
        tick();
        rsp_valid = 1'b1; rsp_data = 32'h55AA_55AA;
        tick();
        rsp_valid = 1'b0;
        #1;
        if (o_stall !== 1'b0) begin $display("FAIL rm_new_stall got=%b exp=0", o_stall); n_fail++; end n_cmp++;
        if (o_rdata !== 32'h55AA_55AA) begin $display("FAIL rm_new_rdata got=%h exp=55aa55aa", o_rdata); n_fail++; end n_cmp++;
        rd = 1'b0;
        tick();
    endtask

    task automatic test_both_and_idle();
        int vcnt = 0;
        rd = 1'b1; wr = 1'b1; addr = 32'h300; wdata = 32'hABCD; ready = 1'b1; rsp_data = 32'hFFFF_0000;
        for (int c = 0; c < 4; c++) begin
            rsp_valid = (c == 2);
            #1;
            vcnt += int'(o_req_valid);
            if (c == 1) begin
                if (o_req_we !== 1'b1) begin $display("FAIL both_we got=%b exp=1", o_req_we); n_fail++; end n_cmp++;
                if (o_req_wdata !== 32'hABCD) begin $display("FAIL both_wdata got=%h exp=0000abcd", o_req_wdata); n_fail++; end n_cmp++;
            end
            if (c == 3) begin
                if (o_stall !== 1'b0) begin $display("FAIL both_stall_done got=%b exp=0", o_stall); n_fail++; end n_cmp++;
                if (o_rdata !== 32'h55AA_55AA) begin $display("FAIL both_rdata_kept got=%h exp=55aa55aa", o_rdata); n_fail++; end n_cmp++;
            end
            tick();
        end
        rd = 1'b0; wr = 1'b0; rsp_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            vcnt += int'(o_req_valid);
            if (o_stall !== 1'b0 || o_req_valid !== 1'b0) begin
                $display("FAIL idle c=%0d got stall=%b valid=%b exp 0 0", c, o_stall, o_req_valid); n_fail++;
            end
            n_cmp++;
            tick();
        end
        if (vcnt !== 1) begin $display("FAIL both_single_txn got=%0d exp=1", vcnt); n_fail++; end n_cmp++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_back_to_back();
        test_timeout_rsp();
        test_timeout_req();
        test_reset_mid();
        test_both_and_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits directly downstream of the core's memory-access stage.
- Converts the core's single-cycle data-memory port (read enable, write enable, address, write data, read data) into a valid/ready request channel plus a response channel, so slow or variable-latency memory can be attached.
- Drives the core's external-stall input while a bus transaction is outstanding.
- Returns read data in the cycle the stall releases.

Parameters:
TIMEOUT, 16, cycles allowed from request capture to completion; 0 disables the timeout.
ERR_DATA, 32'h00000000, read data returned on timeout.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_read_en  in  1  core load request (memory stage)
i_write_en  in  1  core store request (memory stage)
i_addr  in  32  core memory address
i_wdata  in  32  core store data, already lane-aligned
o_rdata  out  32  read data to core
o_stall  out  1  to core external stall; combinational
o_req_valid  out  1  bus request valid
i_req_ready  in  1  bus accepts request
o_req_we  out  1  1 = write, 0 = read
o_req_addr  out  32  registered request address
o_req_wdata  out  32  registered request write data
i_rsp_valid  in  1  bus response valid; every request, read or write, gets exactly one response
i_rsp_data  in  32  bus read data; ignored for writes
o_err  out  1  one-cycle pulse on timeout completion
o_busy  out  1  high in REQ or RSP

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All registered outputs are 0: o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_rdata, o_err, o_busy.
  - Timeout counter is 0.
  - Reset mid-transaction abandons it; no response is awaited afterwards.
- State machine: IDLE, REQ, RSP, DONE.
- IDLE:
  - If i_read_en or i_write_en is high, capture i_addr, i_wdata and we = i_write_en, clear the counter, and go to REQ.
  - If both enables are high, the write takes priority (o_req_we = 1).
- REQ:
  - o_req_valid = 1; addr, wdata and we are held stable.
  - When i_req_ready = 1 at the clock edge, go to RSP and drop o_req_valid.
- RSP:
  - When i_rsp_valid = 1, capture i_rsp_data into o_rdata and go to DONE.
  - i_rsp_valid is sampled only in RSP. Responses arriving in IDLE, REQ or DONE (including late ones after a timeout) are ignored.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE. The core advances at the end of this cycle.
  - o_rdata holds its value until the next DONE; it is not cleared between transactions.
- o_stall = (i_read_en | i_write_en) & (state != DONE):
  - High from the first cycle a request is presented.
  - Low only in DONE.
  - With no request, o_stall = 0.
- Minimum latency:
  - ready already high and response one cycle after acceptance: request in cycle 0, REQ in cycle 1, RSP in cycle 2, DONE in cycle 3.
  - The core therefore sees 3 stall cycles.
- Back-to-back requests: a new request presented in the cycle after DONE re-enters REQ normally. There are no bubbles beyond the IDLE capture cycle.
- Request withdrawn (enables drop) after capture: the transaction still completes. o_stall follows the enables combinationally.
- Timeout (TIMEOUT > 0):
  - The counter increments each cycle in REQ or RSP.
  - When the counter reaches TIMEOUT, go to DONE with o_rdata = ERR_DATA and o_err = 1 for that DONE cycle.
  - A timeout in REQ drops o_req_valid without a handshake.
  - Normal completion in the same cycle as the timeout takes precedence: captured data is used and o_err = 0.
- Width: the counter is at least clog2(TIMEOUT+1) bits, saturating; it never wraps.

Test Plan:
1. Read, ready tied high, response one cycle after accept with data 32'hCAFEF00D, i_addr = 32'h100 → o_req_addr = 32'h100, o_req_we = 0, o_stall high 3 cycles then low in DONE with o_rdata = 32'hCAFEF00D, o_err = 0.
2. Write of 32'h12345678 to 32'h200, i_req_ready held low 4 cycles → o_req_valid stays high with stable addr/data for 4 cycles; after ready, RSP, DONE; o_stall total 6 cycles; o_req_we = 1.
3. Two back-to-back reads to 32'h10 and 32'h14, responses 32'hA and 32'hB → two separate transactions in order; each DONE delivers the matching data; no request overlap.
4. TIMEOUT = 16 with no i_rsp_valid ever → DONE 16 cycles after entering REQ, o_rdata = ERR_DATA, o_err pulses exactly 1 cycle; a response injected 2 cycles later is ignored and the state stays IDLE.
5. rst asserted low while in RSP → all outputs 0 and state IDLE immediately (asynchronous); after release, a new read completes normally.
6. i_read_en and i_write_en both high → o_req_we = 1 and a single transaction; with no request, o_stall = 0 and o_req_valid = 0 for 20 idle cycles.
